// File: rtl/uart_hex_printer.sv
// Renders queued binary words as fixed-width uppercase ASCII hex lines (CR LF terminated) for uart_tx.
// Optional "0x" line prefix is enabled by defining UART_HEX_PREFIX_EN.
module uart_hex_printer #(
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] word_i,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   output logic [7:0]        tx_data_o,
   output logic              tx_data_valid_o,
   input  logic              tx_data_ready_i,
   output logic              busy_o,
   output logic              overflow_o
);

   localparam int DIGITS = WORD_W / 4;
   localparam int NIB_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   // Valid/ready: a byte moves on a posedge where tx_data_valid_o && tx_data_ready_i; the FSM
   // only leaves a byte-emitting state on that transfer, so data and valid hold while stalled.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHAR,
      S_CR,
      S_LF
`ifdef UART_HEX_PREFIX_EN
      ,
      S_PRE0,
      S_PREX
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   shifter_q, shifter_d;
   logic [NIB_W-1:0]    nib_q, nib_d;
   logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                overflow_q, overflow_d;

   logic                full, empty, push, pop, xfer;
   logic [7:0]          tx_byte;
   logic                tx_valid;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n <= 4'd9) return 8'h30 + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction

   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = word_valid_i && !full;
   assign pop   = (state_q == S_LOAD);
   assign xfer  = tx_valid && tx_data_ready_i;

   assign word_ready_o    = !full;
   assign tx_data_o       = tx_byte;
   assign tx_data_valid_o = tx_valid;
   assign busy_o          = (state_q != S_IDLE) || !empty;
   assign overflow_o      = overflow_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      // A push against a full FIFO is lost even when a pop frees a slot in the same cycle.
      overflow_d = overflow_q | (word_valid_i & full);
   end

   always_comb begin
      state_d   = state_q;
      shifter_d = shifter_q;
      nib_d     = nib_q;
      tx_valid  = 1'b0;
      tx_byte   = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (!empty) state_d = S_LOAD;
         end
         S_LOAD: begin
            shifter_d = mem_q[rd_ptr_q];
            nib_d     = NIB_W'(DIGITS - 1);
`ifdef UART_HEX_PREFIX_EN
            state_d   = S_PRE0;
`else
            state_d   = S_CHAR;
`endif
         end
`ifdef UART_HEX_PREFIX_EN
         S_PRE0: begin
            tx_valid = 1'b1;
            tx_byte  = 8'h30;
            if (xfer) state_d = S_PREX;
         end
         S_PREX: begin
            tx_valid = 1'b1;
            tx_byte  = 8'h78;
            if (xfer) state_d = S_CHAR;
         end
`endif
         S_CHAR: begin
            tx_valid = 1'b1;
            tx_byte  = hex_ascii(shifter_q[WORD_W-1 -: 4]);
            if (xfer) begin
               shifter_d = shifter_q << 4;
               if (nib_q == '0) state_d = S_CR;
               else             nib_d   = nib_q - NIB_W'(1);
            end
         end
         S_CR: begin
            tx_valid = 1'b1;
            tx_byte  = 8'h0D;
            if (xfer) state_d = S_LF;
         end
         S_LF: begin
            tx_valid = 1'b1;
            tx_byte  = 8'h0A;
            if (xfer) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shifter_q  <= '0;
         nib_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shifter_q  <= shifter_d;
         nib_q      <= nib_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= word_i;
   end

endmodule

// File: tb/tb_uart_hex_printer.sv
// Scoreboard bench for uart_hex_printer: expected ASCII bytes queued at push, checked on each transfer.
module tb_uart_hex_printer;
  localparam int WORD_W = 32;
  localparam int DIGITS = WORD_W / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WORD_W-1:0] word_i;
  logic              word_valid_i;
  logic              word_ready_o;
  logic [7:0]        tx_data_o;
  logic              tx_data_valid_o;
  logic              tx_data_ready_i;
  logic              busy_o;
  logic              overflow_o;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  int ready_mode = 0;  // 0 stall, 1 always ready, 2 toggle, 3 random

  uart_hex_printer #(.WORD_W(WORD_W), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .word_i          (word_i),
    .word_valid_i    (word_valid_i),
    .word_ready_o    (word_ready_o),
    .tx_data_o       (tx_data_o),
    .tx_data_valid_o (tx_data_valid_o),
    .tx_data_ready_i (tx_data_ready_i),
    .busy_o          (busy_o),
    .overflow_o      (overflow_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: the text line a word should produce
  function automatic void expect_word(input logic [WORD_W-1:0] w);
    string hexs;
    int nib;
    hexs = "0123456789ABCDEF";
`ifdef UART_HEX_PREFIX_EN
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = int'((w >> (4 * i)) & 32'hF);
      exp_q.push_back(hexs[nib]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // ready driver
  initial begin
    tx_data_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_data_ready_i = 1'b0;
        1:       tx_data_ready_i = 1'b1;
        2:       tx_data_ready_i = ~tx_data_ready_i;
        default: tx_data_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: pops expected bytes on transfers, checks hold during stalls
  logic       stall = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic [7:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", tx_data_valid_o, 1'b1);
        check("hold_data", tx_data_o, stall_data);
      end
      if (tx_data_valid_o && tx_data_ready_i) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %h want none at %0t", tx_data_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("byte", tx_data_o, e);
        end
        stall = 1'b0;
      end else if (tx_data_valid_o) begin
        stall = 1'b1;
        stall_data = tx_data_o;
      end else begin
        stall = 1'b0;
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic push(input logic [WORD_W-1:0] w, input bit accept);
    word_i = w;
    word_valid_i = 1'b1;
    if (accept) expect_word(w);
    @(posedge clk);
    #1;
    word_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, (n < 3000), 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    word_valid_i = 1'b0;
    word_i = '0;
    rst_n = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", tx_data_o, 8'h00);
    check("rst_valid", tx_data_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_overflow", overflow_o, 1'b0);
    check("rst_word_ready", word_ready_o, 1'b1);
    rst_n = 1'b1;

    // overflow with a stalled uart: 5 held, 6th dropped
    for (int k = 0; k < 5; k++) begin
      push(32'hA000_0000 + 32'($urandom_range(0, 16'hFFFF)), 1'b1);
      if (k == 3) check("ready_after_4", word_ready_o, 1'b1);
    end
    check("ready_after_5", word_ready_o, 1'b0);
    check("ovf_after_5", overflow_o, 1'b0);
    push(32'hBADBAD00, 1'b0);
    check("ovf_after_6", overflow_o, 1'b1);
    check("ready_after_6", word_ready_o, 1'b0);
    ready_mode = 1;
    wait_drain("drain_overflow");
    check("ovf_sticky", overflow_o, 1'b1);

    // DEADBEEF with latency check
    push(32'hDEADBEEF, 1'b1);
    check("lat_n0_valid", tx_data_valid_o, 1'b0);
    @(posedge clk);
    #1;
    check("lat_n1_valid", tx_data_valid_o, 1'b0);
    @(posedge clk);
    #1;
    check("lat_n2_valid", tx_data_valid_o, 1'b1);
`ifdef UART_HEX_PREFIX_EN
    check("lat_n2_data", tx_data_o, 8'h30);
`else
    check("lat_n2_data", tx_data_o, 8'h44);
`endif
    wait_drain("drain_deadbeef");
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", busy_o, 1'b0);
    check("idle_valid", tx_data_valid_o, 1'b0);

    // toggling ready
    ready_mode = 2;
    push(32'h01234567, 1'b1);
    wait_drain("drain_toggle");

    // back-to-back words, no interleave
    ready_mode = 1;
    push(32'h0000000A, 1'b1);
    push(32'hFFFFFFFF, 1'b1);
    wait_drain("drain_b2b");
    push(32'h00000001, 1'b1);
    wait_drain("drain_one");

    // random bursts that cannot overflow
    ready_mode = 3;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        check("rand_ready", word_ready_o, 1'b1);
        push($urandom, 1'b1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      wait_drain("drain_random");
    end
    check("ovf_still_set", overflow_o, 1'b1);

    // async reset in the middle of a line
    ready_mode = 1;
    base = xfer_cnt;
    push(32'h89ABCDEF, 1'b1);
    n = 0;
    while (xfer_cnt < base + 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mid_reset_reach", (n < 100), 1'b1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", tx_data_valid_o, 1'b0);
    check("arst_data", tx_data_o, 8'h00);
    check("arst_busy", busy_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_ready", word_ready_o, 1'b1);
    check("post_rst_ovf", overflow_o, 1'b0);
    check("post_rst_busy", busy_o, 1'b0);
    check("post_rst_valid", tx_data_valid_o, 1'b0);
    check("post_rst_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
